data_sram_bridge: RTL and testbench
===================================

DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_enM  in  1  M-stage data access valid.
- mem_addrM  in  32  byte address.
- mem_wenM  in  4  byte write strobes; 0 means read.
- writedataM  in  32  store data, already lane-aligned.
- pipe_stall  in  1  stall raised by any other source; the M stage holds while it is 1.
- mem_rdataM  out  32  read word returned to the datapath.
- d_stall  out  1  stall request to the datapath (d_cache_stall).
- data_req  out  1  request valid, sram-like bus.
- data_wr  out  1  1 = write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  request address.
- data_wdata  out  32  write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  read data valid or write done.
- data_rdata  in  32  read data.

REQ-002 The design SHALL be fully synchronous to clk and SHALL use a single clock domain.

Function
REQ-003 The FSM SHALL have states IDLE, ADDR, DATA and DONE.
REQ-004 In IDLE with mem_enM=1, the block SHALL capture the request fields into registers and go to ADDR on the next cycle.
REQ-005 data_req SHALL be 1 only in ADDR; data_wr, data_size, data_addr and data_wdata SHALL stay constant from ADDR entry until addr_ok.
REQ-006 For reads, the block SHALL drive data_size=2 and data_addr={mem_addrM[31:2],2'b00}.
REQ-007 For writes, the block SHALL derive data_size and data_addr[1:0] from mem_wenM as follows.
- 1111: size 2, offset 00.
- 0011: size 1, offset 00.
- 1100: size 1, offset 10.
- One-hot strobe: size 0, offset = index of the set bit.
- Any other strobe pattern SHALL be issued as size 2.
REQ-008 From ADDR, the FSM SHALL transition as follows.
- addr_ok=1 and data_ok=0: go to DATA.
- addr_ok=1 and data_ok=1 in the same cycle: go to DONE.
- addr_ok=0: stay in ADDR.
REQ-009 From DATA, data_ok=1 SHALL move the FSM to DONE; otherwise it SHALL stay in DATA.
REQ-010 On a read completion, data_rdata SHALL be latched into a result register; mem_rdataM SHALL be driven from that register in DONE.
REQ-011 In DONE, pipe_stall=0 SHALL return the FSM to IDLE; pipe_stall=1 SHALL hold DONE and the result register.
REQ-012 d_stall SHALL be combinational and equal to mem_enM AND (state != DONE).
REQ-013 Best-case latency SHALL be: IDLE at c0, ADDR with addr_ok at c1, data_ok at c2, DONE with d_stall=0 at c3.
REQ-014 A data_ok that arrives while no request is outstanding SHALL be ignored.
REQ-015 mem_enM=0 in IDLE SHALL leave the FSM in IDLE with data_req=0.

Reset
REQ-016 Reset SHALL force the following values.
- FSM: IDLE.
- data_req, data_wr: 0.
- data_size: 0.
- data_addr, data_wdata: 0.
- Result register and mem_rdataM: 0.
- Outstanding-write flag: 0.
REQ-017 Reset asserted during ADDR or DATA SHALL abandon the transaction with no completion reported; any later stray data_ok SHALL fall under REQ-014.

Configuration
REQ-018 Macro DATA_SRAM_BRIDGE_WBUF_EN, when defined, SHALL enable posted writes with the following behaviour.
- A write SHALL complete to the pipeline on addr_ok: ADDR goes directly to DONE, and an outstanding-write flag is set.
- The flag SHALL clear on data_ok.
- A new request SHALL NOT leave IDLE while the flag is set, and d_stall SHALL remain 1 during that wait.
- At most one write SHALL be outstanding.
REQ-019 When the macro is undefined, writes SHALL follow REQ-008/009 exactly, and no flag logic SHALL exist.

Structure
REQ-020 A shared package SHALL hold the following items.
- FSM state enum.
- Size encodings SIZE_BYTE, SIZE_HALF and SIZE_WORD.
- Function strb2size returning {size, offset}.
REQ-021 The block SHALL be a single module with no sub-modules; the strobe decode SHALL be the package function.

Verification
REQ-022 Word read at 0x8000_0104 with addr_ok and data_ok one cycle later carrying 0xDEAD_BEEF SHALL produce the following.
- data_addr = 0x8000_0104, data_size = 2.
- d_stall = 1 for 3 cycles.
- mem_rdataM = 0xDEAD_BEEF in DONE.
REQ-023 A byte store with wen=0100, addr 0x8000_0200 and data 0x00AB_0000 SHALL produce data_size=0, data_addr=0x8000_0202 and data_wr=1.
REQ-024 addr_ok held low for 5 cycles SHALL keep data_req=1 with all request fields constant for 5 cycles, and d_stall=1 throughout.
REQ-025 pipe_stall=1 for 4 cycles after data_ok SHALL hold DONE and keep mem_rdataM stable; the next access SHALL start only after pipe_stall drops.
REQ-026 Reset asserted in DATA SHALL force IDLE with data_req=0; a stray data_ok afterwards SHALL cause no state change.
REQ-027 With the macro defined, a write followed immediately by a read, with the write's data_ok 3 cycles late, SHALL produce the following.
- The write releases d_stall on addr_ok.
- The read's data_req is not asserted until the write's data_ok is seen.

Source files
------------

// File: rtl/data_sram_bridge_pkg.sv
// Shared FSM state, bus size encodings and write-strobe decode for data_sram_bridge.
package data_sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Returns {size, byte offset}; unsupported strobe patterns go out as a full word.
  function automatic logic [3:0] strb2size(input logic [3:0] strb);
    logic [3:0] w_res;
    w_res = {SIZE_WORD, 2'b00};
    case (strb)
      4'b1111: w_res = {SIZE_WORD, 2'b00};
      4'b0011: w_res = {SIZE_HALF, 2'b00};
      4'b1100: w_res = {SIZE_HALF, 2'b10};
      4'b0001: w_res = {SIZE_BYTE, 2'b00};
      4'b0010: w_res = {SIZE_BYTE, 2'b01};
      4'b0100: w_res = {SIZE_BYTE, 2'b10};
      4'b1000: w_res = {SIZE_BYTE, 2'b11};
      default: w_res = {SIZE_WORD, 2'b00};
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/data_sram_bridge.sv
// Bridges the M-stage data access onto an sram-like bus and stalls the datapath until done.
// Optional macro DATA_SRAM_BRIDGE_WBUF_EN: posted writes, completing on addr_ok, one outstanding.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enM,
  input  logic [31:0] mem_addrM,
  input  logic [3:0]  mem_wenM,
  input  logic [31:0] writedataM,
  input  logic        pipe_stall,
  output logic [31:0] mem_rdataM,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  state_t      r_state;
  state_t      w_next;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  w_sz_off;
  logic        w_is_wr;
  logic        w_launch;
  logic        w_post;
  logic        w_rd_done;
  logic        w_unused_addr;

  assign w_sz_off      = strb2size(mem_wenM);
  assign w_is_wr       = |mem_wenM;
  assign w_unused_addr = ^mem_addrM[1:0];
  assign w_rd_done     = ~r_wr & data_data_ok &
                         (((r_state == ADDR) & data_addr_ok) | (r_state == DATA));

`ifdef DATA_SRAM_BRIDGE_WBUF_EN
  logic r_wpend;

  // A posted write holds new requests in IDLE until its data_ok returns.
  assign w_launch = mem_enM & ~r_wpend;
  assign w_post   = r_wr & data_addr_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wpend <= 1'b0;
    end else if ((r_state == ADDR) && data_addr_ok && r_wr && !data_data_ok) begin
      r_wpend <= 1'b1;
    end else if (data_data_ok) begin
      r_wpend <= 1'b0;
    end
  end
`else
  assign w_launch = mem_enM;
  assign w_post   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_launch) w_next = ADDR;
      ADDR: begin
        if (data_addr_ok) begin
          w_next = (data_data_ok || w_post) ? DONE : DATA;
        end
      end
      DATA: if (data_data_ok) w_next = DONE;
      DONE: if (!pipe_stall) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if ((r_state == IDLE) && w_launch) begin
        r_wr    <= w_is_wr;
        r_size  <= w_is_wr ? w_sz_off[3:2] : SIZE_WORD;
        r_addr  <= {mem_addrM[31:2], (w_is_wr ? w_sz_off[1:0] : 2'b00)};
        r_wdata <= writedataM;
      end
      if (w_rd_done) begin
        r_rdata <= data_rdata;
      end
    end
  end

  assign data_req   = (r_state == ADDR);
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;
  assign mem_rdataM = r_rdata;
  assign d_stall    = mem_enM & (r_state != DONE);

endmodule

// File: tb/tb_data_sram_bridge.sv
// Scoreboard bench for data_sram_bridge: reference memory model, randomized sram-like slave.
module tb_data_sram_bridge;

  localparam int unsigned BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_enM = 1'b0;
  logic [31:0] mem_addrM = '0;
  logic [3:0]  mem_wenM = '0;
  logic [31:0] writedataM = '0;
  logic        pipe_stall = 1'b0;
  logic [31:0] mem_rdataM;
  logic        d_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;

  data_sram_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .mem_enM     (mem_enM),
    .mem_addrM   (mem_addrM),
    .mem_wenM    (mem_wenM),
    .writedataM  (writedataM),
    .pipe_stall  (pipe_stall),
    .mem_rdataM  (mem_rdataM),
    .d_stall     (d_stall),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        is_rd;
    logic [31:0] rdata;
  } cpl_t;

  req_t        req_q[$];
  cpl_t        cpl_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] sram [16];
  logic [3:0]  wens [10] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6, 4'h5, 4'hE};

  int checks = 0;
  int errors = 0;
  bit slave_en = 1'b0;
  bit rand_ps = 1'b0;
  bit chk_order = 1'b0;
  int cfg_alat = 0;
  int cfg_dlat = 1;
  int unsigned ps_hold = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic end_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Reference: what the bus must see and what the pipeline must get back.
  task automatic expect_access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    logic [1:0]  sz;
    logic [1:0]  off;
    logic [3:0]  mask;
    int unsigned idx;
    req_t        r;
    cpl_t        c;
    idx  = a[5:2];
    sz   = 2'd2;
    off  = 2'd0;
    mask = 4'hF;
    case (w)
      4'h3: begin sz = 2'd1; off = 2'd0; mask = 4'h3; end
      4'hC: begin sz = 2'd1; off = 2'd2; mask = 4'hC; end
      4'h1: begin sz = 2'd0; off = 2'd0; mask = 4'h1; end
      4'h2: begin sz = 2'd0; off = 2'd1; mask = 4'h2; end
      4'h4: begin sz = 2'd0; off = 2'd2; mask = 4'h4; end
      4'h8: begin sz = 2'd0; off = 2'd3; mask = 4'h8; end
      default: ;
    endcase
    if (w == 4'h0) begin
      r = '{1'b0, 2'd2, {a[31:2], 2'b00}, d};
    end else begin
      r = '{1'b1, sz, {a[31:2], off}, d};
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
      end
    end
    req_q.push_back(r);
    c.is_rd = (w == 4'h0);
    c.rdata = ref_mem[idx];
    cpl_q.push_back(c);
  endtask

  // One M-stage slot; returns cycles with d_stall high and cycles spent completed-but-held.
  task automatic do_access(input logic en, input logic [31:0] a, input logic [3:0] w,
                           input logic [31:0] d, output int unsigned nstall,
                           output int unsigned ndone);
    int unsigned cyc;
    bit fin;
    cyc = 0;
    fin = 1'b0;
    nstall = 0;
    ndone = 0;
    mem_enM = en;
    mem_addrM = a;
    mem_wenM = w;
    writedataM = d;
    if (en) expect_access(a, w, d);
    if (!rand_ps) pipe_stall = (ps_hold > 0);
    while (!fin) begin
      @(negedge clk);
      if (en && d_stall) nstall++;
      if (en && !d_stall) ndone++;
      if (!(en && d_stall) && !pipe_stall) begin
        fin = 1'b1;
      end else begin
        cyc++;
        if (cyc > BUDGET) begin
          checks++;
          errors++;
          $display("FAIL slot_timeout actual=%0d cycles required<=%0d", cyc, BUDGET);
          end_run();
        end
      end
      @(posedge clk);
      #1;
      if (rand_ps) pipe_stall = ($urandom_range(0, 3) == 0);
      else pipe_stall = (ndone < ps_hold);
    end
    mem_enM = 1'b0;
  endtask

  // sram-like slave with programmable or random addr_ok / data_ok latency.
  initial begin
    bit          pend;
    int unsigned dcnt;
    int unsigned wait_a;
    int unsigned alat;
    int unsigned lat;
    int unsigned pidx;
    int unsigned lane;
    pend = 1'b0;
    dcnt = 0;
    wait_a = 0;
    alat = 0;
    pidx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (slave_en) begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (!rst) begin
          pend = 1'b0;
          wait_a = 0;
        end else if (pend) begin
          if (dcnt == 0) begin
            data_data_ok = 1'b1;
            data_rdata = sram[pidx];
            pend = 1'b0;
          end else begin
            dcnt--;
          end
        end else if (data_req) begin
          if (wait_a == 0) alat = (cfg_alat < 0) ? $urandom_range(0, 3) : cfg_alat;
          if (wait_a >= alat) begin
            data_addr_ok = 1'b1;
            wait_a = 0;
            pidx = data_addr[5:2];
            lat = (cfg_dlat < 0) ? $urandom_range(0, 3) : cfg_dlat;
            if (data_wr) begin
              lane = data_addr[1:0];
              case (data_size)
                2'd0: sram[pidx][8*lane +: 8] = data_wdata[8*lane +: 8];
                2'd1: begin
                  lane = {data_addr[1], 1'b0};
                  sram[pidx][8*lane +: 16] = data_wdata[8*lane +: 16];
                end
                default: sram[pidx] = data_wdata;
              endcase
            end
            if (lat == 0) begin
              data_data_ok = 1'b1;
              data_rdata = sram[pidx];
            end else begin
              pend = 1'b1;
              dcnt = lat - 1;
            end
          end else begin
            wait_a++;
          end
        end
      end
    end
  end

  // Monitor: bus requests against the request queue, pipeline results against completions.
  initial begin
    bit   p_pend;
    bit   ord_seen;
    req_t prev;
    req_t e;
    cpl_t c;
    p_pend = 1'b0;
    ord_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        p_pend = 1'b0;
      end else begin
        if (chk_order) begin
          if (data_data_ok) ord_seen = 1'b1;
          if (data_req) begin
            chk("req_before_write_data_ok", {31'd0, ord_seen}, 32'd1);
            chk_order = 1'b0;
            ord_seen = 1'b0;
          end
        end
        if (data_req) begin
          if (p_pend) begin
            chk("hold_wr", {31'd0, data_wr}, {31'd0, prev.wr});
            chk("hold_size", {30'd0, data_size}, {30'd0, prev.size});
            chk("hold_addr", data_addr, prev.addr);
            chk("hold_wdata", data_wdata, prev.wdata);
          end
          if (data_addr_ok) begin
            p_pend = 1'b0;
            if (req_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious_req actual=addr 0x%08h required=no request", data_addr);
            end else begin
              e = req_q.pop_front();
              chk("req_wr", {31'd0, data_wr}, {31'd0, e.wr});
              chk("req_size", {30'd0, data_size}, {30'd0, e.size});
              chk("req_addr", data_addr, e.addr);
              if (e.wr) chk("req_wdata", data_wdata, e.wdata);
            end
          end else begin
            p_pend = 1'b1;
            prev = '{data_wr, data_size, data_addr, data_wdata};
          end
        end
        if (mem_enM && !d_stall) begin
          if (cpl_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_completion actual=d_stall 0 required=no completion");
          end else begin
            c = cpl_q[0];
            if (c.is_rd) chk("rdata", mem_rdataM, c.rdata);
            if (!pipe_stall) void'(cpl_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=run completes");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned ns;
    int unsigned nd;
    int unsigned k;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      sram[i] = '0;
    end
    mem_enM = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data_req", {31'd0, data_req}, 32'd0);
    chk("rst_data_wr", {31'd0, data_wr}, 32'd0);
    chk("rst_data_size", {30'd0, data_size}, 32'd0);
    chk("rst_data_addr", data_addr, 32'd0);
    chk("rst_data_wdata", data_wdata, 32'd0);
    chk("rst_rdata", mem_rdataM, 32'd0);
    chk("rst_d_stall_idle", {31'd0, d_stall}, 32'd1);
    mem_enM = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    slave_en = 1'b1;

    sram[1] = 32'hDEAD_BEEF;
    ref_mem[1] = 32'hDEAD_BEEF;
    cfg_alat = 0;
    cfg_dlat = 1;
    do_access(1'b1, 32'h8000_0104, 4'h0, 32'h0, ns, nd);
    chk("read_stall_cycles", ns, 32'd3);

    do_access(1'b1, 32'h8000_0200, 4'b0100, 32'h00AB_0000, ns, nd);

    cfg_alat = 5;
    do_access(1'b1, 32'h8000_0200, 4'h0, 32'h0, ns, nd);
    chk("addr_wait_stall_cycles", ns, 32'd8);

    cfg_alat = 0;
    ps_hold = 4;
    do_access(1'b1, 32'h8000_0104, 4'h0, 32'h0, ns, nd);
    chk("pipe_stall_done_cycles", nd, 32'd5);
    ps_hold = 0;
    do_access(1'b1, 32'h8000_0108, 4'h0, 32'h0, ns, nd);
    chk("after_hold_stall_cycles", ns, 32'd3);

    // Reset in DATA, then a stray data_ok with nothing outstanding.
    slave_en = 1'b0;
    @(posedge clk);
    #1;
    mem_enM = 1'b1;
    mem_addrM = 32'h8000_0040;
    mem_wenM = 4'h0;
    expect_access(32'h8000_0040, 4'h0, 32'h0);
    @(posedge clk);
    #1 data_addr_ok = 1'b1;
    @(posedge clk);
    #1 data_addr_ok = 1'b0;
    @(negedge clk);
    chk("data_state_req", {31'd0, data_req}, 32'd0);
    chk("data_state_stall", {31'd0, d_stall}, 32'd1);
    #1;
    rst = 1'b0;
    mem_enM = 1'b0;
    #1;
    chk("abort_req", {31'd0, data_req}, 32'd0);
    chk("abort_size", {30'd0, data_size}, 32'd0);
    chk("abort_addr", data_addr, 32'd0);
    chk("abort_rdata", mem_rdataM, 32'd0);
    cpl_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    data_data_ok = 1'b1;
    data_rdata = 32'h1234_5678;
    @(posedge clk);
    #1 data_data_ok = 1'b0;
    @(negedge clk);
    chk("stray_ok_req", {31'd0, data_req}, 32'd0);
    chk("stray_ok_rdata", mem_rdataM, 32'd0);
    @(posedge clk);
    #1;
    slave_en = 1'b1;
    do_access(1'b1, 32'h8000_0104, 4'h0, 32'h0, ns, nd);
    chk("post_reset_stall_cycles", ns, 32'd3);

`ifdef DATA_SRAM_BRIDGE_WBUF_EN
    cfg_dlat = 3;
    do_access(1'b1, 32'h8000_0010, 4'hF, 32'hCAFE_F00D, ns, nd);
    chk("posted_write_stall_cycles", ns, 32'd2);
    chk_order = 1'b1;
    cfg_dlat = 1;
    do_access(1'b1, 32'h8000_0010, 4'h0, 32'h0, ns, nd);
`endif

    rand_ps = 1'b1;
    cfg_alat = -1;
    cfg_dlat = -1;
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      a = 32'h8000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if (k < 2) do_access(1'b0, a, 4'h0, 32'h0, ns, nd);
      else if (k < 6) do_access(1'b1, a, 4'h0, 32'h0, ns, nd);
      else do_access(1'b1, a, wens[$urandom_range(0, 9)], $urandom, ns, nd);
    end
    rand_ps = 1'b0;
    pipe_stall = 1'b0;
    mem_enM = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("req_queue_drained", req_q.size(), 32'd0);
    chk("cpl_queue_drained", cpl_q.size(), 32'd0);
    end_run();
  end

endmodule
